jk_bank_seq: RTL

- Sequencer for a bank of WIDTH gate-level master-slave JK flip-flops (per-bit clk/cl/j/k inputs, q output).
- Accepts one command at a time over a valid/ready handshake.
- Drives per-bit J/K plus a bank clock strobe and bank clear, waits for the gate network to settle, then checks bank readback against an internal expected-value mirror.
- Used wherever the team needs a JK bank to act as a loadable up/down counter or register.

---
 rtl/jk_seq_pkg.sv | 32 +++
 rtl/jk_bank_seq_if.sv | 35 +++
 rtl/jk_next_calc.sv | 68 ++++++
 rtl/jk_bank_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK bank sequencer.
//   OP_W     : width of the command opcode field
//   op_e     : command opcodes
//   state_e  : sequencer FSM states
//   is_count : true for the multi-step UP/DOWN ops
package jk_seq_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OpHold  = 3'd0,
    OpClear = 3'd1,
    OpSet   = 3'd2,
    OpLoad  = 3'd3,
    OpUp    = 3'd4,
    OpDown  = 3'd5,
    OpSync  = 3'd6,
    OpRsvd  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck
  } state_e;

  function automatic logic is_count(op_e op);
    return (op == OpUp) || (op == OpDown);
  endfunction

endpackage

// File: rtl/jk_bank_seq_if.sv
// Command handshake bundle for jk_bank_seq.
//   cmd_valid : command present (master -> slave)
//   cmd_ready : sequencer idle, command accepted on valid && ready (slave -> master)
//   cmd_op    : opcode, see jk_seq_pkg::op_e
//   cmd_data  : LOAD value
//   cmd_cnt   : UP/DOWN step count, 0 means 1
interface jk_bank_seq_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
);
  import jk_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_cnt,
    output cmd_ready
  );

endinterface

// File: rtl/jk_next_calc.sv
// Combinational J/K and next-state calculator for a bank of JK flip-flops.
//   op     : current opcode
//   q_exp  : present expected bank value
//   data   : LOAD value
//   j, k   : per-bit J/K for the op
//   q_next : bank value after one strobe with those J/K
module jk_next_calc
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] q_exp,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;

  // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  // Scalar accumulators keep the chain free of self-referencing vectors.
  always_comb begin
    logic acc_up;
    logic acc_dn;
    t_up   = '0;
    t_dn   = '0;
    acc_up = 1'b1;
    acc_dn = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      t_up[i] = acc_up;
      t_dn[i] = acc_dn;
      acc_up  = acc_up & q_exp[i];
      acc_dn  = acc_dn & ~q_exp[i];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    case (op)
      OpClear: k = '1;
      OpSet:   j = '1;
      OpLoad: begin
        j = data;
        k = ~data;
      end
      OpUp: begin
        j = t_up;
        k = t_up;
      end
      OpDown: begin
        j = t_dn;
        k = t_dn;
      end
      default: begin
        j = '0;
        k = '0;
      end
    endcase
  end

  // JK characteristic equation: Q+ = J & ~Q | ~K & Q.
  assign q_next = (j & ~q_exp) | (~k & q_exp);

endmodule

// File: rtl/jk_bank_seq.sv
// Sequencer for a bank of WIDTH master-slave JK flip-flops.
// Accepts one command over cmd (valid/ready), strobes the bank with per-bit J/K,
// waits SETTLE_CYC cycles, then updates the expected-value mirror q_exp.
// Optional macro JKSEQ_VERIFY_EN enables readback compare and the sticky err flag;
// without it err is constant 0 and jk_q is only read by SYNC.
// Ports:
//   clk, cl      : clock (rising edge), asynchronous active-low reset
//   cmd          : command interface (slave side)
//   jk_j, jk_k   : per-bit J/K to the bank
//   jk_clk       : bank clock strobe, high for one cycle per step
//   jk_cl        : registered active-low bank clear
//   jk_q         : bank readback
//   q_exp        : expected bank value
//   busy, done   : not-idle flag, one-cycle completion pulse
//   err          : sticky readback-mismatch flag
module jk_bank_seq
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             cl,
  jk_bank_seq_if.slave     cmd,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             jk_clk,
  output logic             jk_cl,
  input  logic [WIDTH-1:0] jk_q,
  output logic [WIDTH-1:0] q_exp,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [WIDTH-1:0] q_exp_q, q_exp_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             jk_cl_q;

  logic [WIDTH-1:0] calc_j, calc_k, calc_q_next;
  logic             mismatch;
  logic             drive_jk;

  jk_next_calc #(
    .WIDTH (WIDTH)
  ) u_next_calc (
    .op     (op_q),
    .q_exp  (q_exp_q),
    .data   (data_q),
    .j      (calc_j),
    .k      (calc_k),
    .q_next (calc_q_next)
  );

`ifdef JKSEQ_VERIFY_EN
  assign mismatch = (jk_q != calc_q_next);
`else
  assign mismatch = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    steps_d  = steps_q;
    settle_d = settle_q;
    q_exp_d  = q_exp_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          op_d    = op_e'(cmd.cmd_op);
          data_d  = cmd.cmd_data;
          steps_d = (cmd.cmd_cnt == '0) ? CNT_W'(1) : cmd.cmd_cnt;
          state_d = (op_e'(cmd.cmd_op) == OpSync) ? StCheck : StDrive;
        end
      end
      StDrive: begin
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          state_d = StCheck;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      StCheck: begin
        if (op_q == OpSync) begin
          q_exp_d = jk_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          // Mirror always advances, even when readback disagrees.
          q_exp_d = calc_q_next;
          if (mismatch) begin
            err_d = 1'b1;
          end
          if (is_count(op_q) && (steps_q > CNT_W'(1)) && !mismatch) begin
            steps_d = steps_q - CNT_W'(1);
            state_d = StDrive;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge cl) begin
    if (!cl) begin
      state_q  <= StIdle;
      op_q     <= OpHold;
      data_q   <= '0;
      steps_q  <= '0;
      settle_q <= '0;
      q_exp_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      jk_cl_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      steps_q  <= steps_d;
      settle_q <= settle_d;
      q_exp_q  <= q_exp_d;
      done_q   <= done_d;
      err_q    <= err_d;
      jk_cl_q  <= 1'b1;
    end
  end

  // J/K stay stable from the strobe through settle so the slave latches clean data.
  assign drive_jk      = (state_q == StDrive) || (state_q == StSettle);
  assign jk_j          = drive_jk ? calc_j : '0;
  assign jk_k          = drive_jk ? calc_k : '0;
  assign jk_clk        = (state_q == StDrive);
  assign jk_cl         = jk_cl_q;
  assign q_exp         = q_exp_q;
  assign busy          = (state_q != StIdle);
  assign cmd.cmd_ready = (state_q == StIdle);
  assign done          = done_q;
  assign err           = err_q;

endmodule
